fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the program-counter/instruction-memory fetch path and the decode stage.
- Captures {PC, instruction} pairs produced each fetch cycle and presents them to decode in order.
- Its PushReady output drives the PC register's NotStall input, so the PC holds whenever the queue is full.
- Flush discards all buffered entries on a branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- ADDR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
- PushValid  input  1  fetch side presents a valid pair this cycle.
- PushPC  input  32  PC of the fetched instruction.
- PushInstr  input  32  fetched instruction word.
- PushReady  output  1  queue can accept a push; wired to the PC's NotStall.
- PopValid  output  1  head entry is valid.
- PopPC  output  32  PC of the head entry.
- PopInstr  output  32  instruction of the head entry.
- PopReady  input  1  decode consumes the head entry this cycle.
- Flush  input  1  discard all entries (redirect).
- Count  output  ADDR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset has priority over every other input.
- Reset state:
  - Read pointer, write pointer and Count are 0.
  - PushReady = 1, PopValid = 0, PopPC = 0, PopInstr = 0.
  - Storage contents are don't-care.
- Output decode:
  - PushReady = (Count != DEPTH) and not Reset. It is combinational from registered state and does not depend on PopReady, so there is no pass-through push when full.
  - PopValid = (Count != 0).
  - PopPC/PopInstr show the entry at the read pointer when PopValid = 1, and are forced to 0 when PopValid = 0.
- Transfer conditions:
  - Push occurs when PushValid and PushReady are both 1: the entry is written at the write pointer, and the write pointer increments modulo DEPTH.
  - Pop occurs when PopValid and PopReady are both 1: the read pointer increments modulo DEPTH.
- Count update:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle: unchanged. This is legal when full (pop only) and when Count = 1.
- Latency: a pushed entry appears on the Pop outputs the cycle after its push edge. There is no same-cycle bypass while empty.
- Ordering: strict FIFO, and the PC/instruction pairing is preserved.
- Boundary conditions:
  - PushValid while full is ignored, with no state change; the fetch side must hold its data because the PC is stalled.
  - PopReady while empty is ignored.
  - Pointer wrap from DEPTH-1 to 0 is seamless; Count distinguishes full from empty.
- Flush:
  - Priority is below Reset and above push/pop.
  - On the edge where Flush = 1, both pointers and Count go to 0.
  - Any push or pop presented in the same cycle is discarded.
  - The next cycle shows PopValid = 0 and PushReady = 1.
- Reset mid-stream: same effect as Flush, and all outputs return to their reset values on the next cycle.
- Flush and Reset together: Reset behaviour applies.
- No X propagation: outputs are defined at all times after the first reset edge.

Test Plan:
- Reset then fill:
  - Stimulus: assert Reset for 2 cycles, then push PC 0x00,0x04,0x08,0x0C with instructions 0x20080001..0x20080004 and PopReady = 0.
  - Required: Count goes 1,2,3,4; PushReady = 0 after the 4th push; a 5th push of PC 0x10 is ignored and Count stays 4.
- Drain order and empty:
  - Stimulus: from full, hold PopReady = 1 for 5 cycles.
  - Required: PopPC 0x00,0x04,0x08,0x0C in order with matching instructions; then PopValid = 0, PopPC = 0, and Count = 0.
- Simultaneous push/pop:
  - Stimulus: with Count = 2, push PC 0x40 and pop in the same cycle for 6 cycles.
  - Required: Count stays 2, pointers wrap past 3→0, and the pop sequence continues in order without loss.
- Full with simultaneous pop:
  - Stimulus: Count = 4, PopReady = 1, PushValid = 1.
  - Required: the push is rejected (PushReady = 0), the pop succeeds, and Count = 3; the push is accepted the following cycle.
- Flush:
  - Stimulus: Count = 3, assert Flush with PushValid = 1 (PC 0x100).
  - Required: next cycle Count = 0, PopValid = 0, PushReady = 1, and 0x100 is never popped; a subsequent push of 0x200 pops first.
- Reset mid-operation:
  - Stimulus: Count = 2, assert Reset together with Flush and PopReady.
  - Required: all outputs return to reset values the next cycle, and Count = 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: {PC, instruction} prefetch FIFO between the fetch path and decode.
// PushReady feeds the PC register's NotStall, so the PC holds while the queue is full.
// Flush empties the queue on a redirect; Reset also empties it and takes priority over Flush.
module fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PushValid,
  input  logic [31:0]       PushPC,
  input  logic [31:0]       PushInstr,
  output logic              PushReady,
  output logic              PopValid,
  output logic [31:0]       PopPC,
  output logic [31:0]       PopInstr,
  input  logic              PopReady,
  input  logic              Flush,
  output logic [ADDR_W:0]   Count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  // One buffered fetch result; PC and instruction travel together.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t      mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              push_fire_c;
  logic              pop_fire_c;
  logic              full_c;
  logic              empty_c;
  fetch_entry_t      head_c;

  // Occupancy flags and handshakes, all derived from registered state.
  always_comb begin
    full_c      = (count_q == FULL_COUNT);
    empty_c     = (count_q == '0);
    push_fire_c = PushValid && !full_c && !Reset;
    pop_fire_c  = PopReady && !empty_c;
  end

  // Pointer and occupancy update; Reset, then Flush, override any transfer.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire_c) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_fire_c) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_fire_c, pop_fire_c})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge Clk) begin
    if (push_fire_c && !Flush) begin
      mem[wr_ptr] <= '{pc: PushPC, instr: PushInstr};
    end
  end

  // Head presentation; payload is zeroed when nothing is valid so outputs never carry stale data.
  always_comb begin
    head_c    = mem[rd_ptr];
    PushReady = !full_c && !Reset;
    PopValid  = !empty_c;
    PopPC     = '0;
    PopInstr  = '0;
    Count     = count_q;
    if (!empty_c) begin
      PopPC    = head_c.pc;
      PopInstr = head_c.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue covering fill, drain, wrap, full/pop, flush and reset.
module tb_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic        PushValid;
  logic [31:0] PushPC;
  logic [31:0] PushInstr;
  logic        PushReady;
  logic        PopValid;
  logic [31:0] PopPC;
  logic [31:0] PopInstr;
  logic        PopReady;
  logic        Flush;
  logic [2:0]  Count;

  int n_cmp;
  int n_err;

  fetch_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PushValid (PushValid),
    .PushPC    (PushPC),
    .PushInstr (PushInstr),
    .PushReady (PushReady),
    .PopValid  (PopValid),
    .PopPC     (PopPC),
    .PopInstr  (PopInstr),
    .PopReady  (PopReady),
    .Flush     (Flush),
    .Count     (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    PushValid = 1'b0;
    PushPC    = 32'h0;
    PushInstr = 32'h0;
    PopReady  = 1'b0;
    Flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (PushReady !== 1'b0) begin n_err++; $display("FAIL reset_pushready_held: got %b want 0", PushReady); end
    n_cmp++; if (Count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", Count); end
    n_cmp++; if (PopValid !== 1'b0) begin n_err++; $display("FAIL reset_popvalid: got %b want 0", PopValid); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (PushReady !== 1'b1) begin n_err++; $display("FAIL reset_pushready: got %b want 1", PushReady); end
    n_cmp++; if (PopPC !== 32'h0 || PopInstr !== 32'h0) begin n_err++; $display("FAIL reset_payload: got %h/%h want 0/0", PopPC, PopInstr); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      PushValid = 1'b1;
      PushPC    = 32'(i * 4);
      PushInstr = 32'h2008_0001 + 32'(i);
      tick();
      n_cmp++; if (Count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, Count, i + 1); end
      n_cmp++; if (PopPC !== 32'h0 || PopValid !== 1'b1) begin n_err++; $display("FAIL fill_head[%0d]: got %h v=%b want 0 v=1", i, PopPC, PopValid); end
    end
    n_cmp++; if (PushReady !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", PushReady); end
    PushPC    = 32'h10;
    PushInstr = 32'h2008_0005;
    tick();
    n_cmp++; if (Count !== 3'd4) begin n_err++; $display("FAIL fill_ignored_count: got %0d want 4", Count); end
    n_cmp++; if (PopPC !== 32'h0) begin n_err++; $display("FAIL fill_ignored_head: got %h want 0", PopPC); end
    idle_inputs();
  endtask

  task automatic test_drain();
    PopReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (PopPC !== 32'(i * 4)) begin n_err++; $display("FAIL drain_pc[%0d]: got %h want %h", i, PopPC, i * 4); end
      n_cmp++; if (PopInstr !== 32'h2008_0001 + 32'(i)) begin n_err++; $display("FAIL drain_instr[%0d]: got %h want %h", i, PopInstr, 32'h2008_0001 + 32'(i)); end
      tick();
    end
    n_cmp++; if (PopValid !== 1'b0 || PopPC !== 32'h0 || Count !== 3'd0) begin n_err++; $display("FAIL drain_empty: got v=%b pc=%h cnt=%0d want v=0 pc=0 cnt=0", PopValid, PopPC, Count); end
    tick();
    n_cmp++; if (Count !== 3'd0 || PopValid !== 1'b0) begin n_err++; $display("FAIL drain_pop_empty: got cnt=%0d v=%b want 0/0", Count, PopValid); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_pc [6];
    exp_pc = '{32'h20, 32'h24, 32'h40, 32'h44, 32'h48, 32'h4C};
    PushValid = 1'b1;
    PushPC = 32'h20; PushInstr = 32'hA000_0020; tick();
    PushPC = 32'h24; PushInstr = 32'hA000_0024; tick();
    n_cmp++; if (Count !== 3'd2) begin n_err++; $display("FAIL simul_setup_count: got %0d want 2", Count); end
    PopReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      PushPC    = 32'h40 + 32'(k * 4);
      PushInstr = 32'hA000_0040 + 32'(k * 4);
      n_cmp++; if (PopPC !== exp_pc[k] || PopInstr !== (32'hA000_0000 | exp_pc[k])) begin n_err++; $display("FAIL simul_pop[%0d]: got %h/%h want %h/%h", k, PopPC, PopInstr, exp_pc[k], 32'hA000_0000 | exp_pc[k]); end
      tick();
      n_cmp++; if (Count !== 3'd2) begin n_err++; $display("FAIL simul_count[%0d]: got %0d want 2", k, Count); end
    end
    idle_inputs();
    n_cmp++; if (PopPC !== 32'h50) begin n_err++; $display("FAIL simul_head_after: got %h want 50", PopPC); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h54, 32'h58, 32'h5C, 32'h60};
    PushValid = 1'b1;
    PushPC = 32'h58; PushInstr = 32'hA000_0058; tick();
    PushPC = 32'h5C; PushInstr = 32'hA000_005C; tick();
    n_cmp++; if (Count !== 3'd4) begin n_err++; $display("FAIL fullpop_setup_count: got %0d want 4", Count); end
    PushPC = 32'h60; PushInstr = 32'hA000_0060;
    PopReady = 1'b1;
    n_cmp++; if (PushReady !== 1'b0) begin n_err++; $display("FAIL fullpop_ready: got %b want 0", PushReady); end
    n_cmp++; if (PopPC !== 32'h50) begin n_err++; $display("FAIL fullpop_head: got %h want 50", PopPC); end
    tick();
    n_cmp++; if (Count !== 3'd3 || PopPC !== 32'h54) begin n_err++; $display("FAIL fullpop_after: got cnt=%0d pc=%h want 3/54", Count, PopPC); end
    PopReady = 1'b0;
    n_cmp++; if (PushReady !== 1'b1) begin n_err++; $display("FAIL fullpop_ready_again: got %b want 1", PushReady); end
    tick();
    n_cmp++; if (Count !== 3'd4) begin n_err++; $display("FAIL fullpop_accept: got %0d want 4", Count); end
    PushValid = 1'b0;
    PopReady  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (PopPC !== exp_pc[i] || PopInstr !== (32'hA000_0000 | exp_pc[i])) begin n_err++; $display("FAIL fullpop_drain[%0d]: got %h/%h want %h", i, PopPC, PopInstr, exp_pc[i]); end
      tick();
    end
    n_cmp++; if (Count !== 3'd0) begin n_err++; $display("FAIL fullpop_empty: got %0d want 0", Count); end
    idle_inputs();
  endtask

  task automatic test_flush();
    PushValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PushPC    = 32'h70 + 32'(i * 4);
      PushInstr = 32'hB000_0070 + 32'(i * 4);
      tick();
    end
    n_cmp++; if (Count !== 3'd3) begin n_err++; $display("FAIL flush_setup_count: got %0d want 3", Count); end
    Flush     = 1'b1;
    PopReady  = 1'b1;
    PushPC    = 32'h100;
    PushInstr = 32'hB000_0100;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (Count !== 3'd0 || PopValid !== 1'b0 || PushReady !== 1'b1) begin n_err++; $display("FAIL flush_state: got cnt=%0d v=%b rdy=%b want 0/0/1", Count, PopValid, PushReady); end
    n_cmp++; if (PopPC !== 32'h0) begin n_err++; $display("FAIL flush_payload: got %h want 0", PopPC); end
    PushValid = 1'b1;
    PushPC    = 32'h200;
    PushInstr = 32'hB000_0200;
    tick();
    PushValid = 1'b0;
    n_cmp++; if (PopPC !== 32'h200 || PopInstr !== 32'hB000_0200 || Count !== 3'd1) begin n_err++; $display("FAIL flush_next_push: got %h/%h cnt=%0d want 200/b0000200 cnt=1", PopPC, PopInstr, Count); end
    PopReady = 1'b1;
    tick();
    n_cmp++; if (Count !== 3'd0 || PopValid !== 1'b0) begin n_err++; $display("FAIL flush_no_stale: got cnt=%0d v=%b pc=%h want 0/0", Count, PopValid, PopPC); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    PushValid = 1'b1;
    PushPC = 32'h300; PushInstr = 32'hC000_0300; tick();
    PushPC = 32'h304; PushInstr = 32'hC000_0304; tick();
    n_cmp++; if (Count !== 3'd2) begin n_err++; $display("FAIL rstmid_setup_count: got %0d want 2", Count); end
    Reset    = 1'b1;
    Flush    = 1'b1;
    PopReady = 1'b1;
    PushPC   = 32'h308;
    tick();
    Reset = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (Count !== 3'd0 || PopValid !== 1'b0 || PushReady !== 1'b1) begin n_err++; $display("FAIL rstmid_state: got cnt=%0d v=%b rdy=%b want 0/0/1", Count, PopValid, PushReady); end
    n_cmp++; if (PopPC !== 32'h0 || PopInstr !== 32'h0) begin n_err++; $display("FAIL rstmid_payload: got %h/%h want 0/0", PopPC, PopInstr); end
    PushValid = 1'b1;
    PushPC = 32'h400; PushInstr = 32'hC000_0400; tick();
    PushValid = 1'b0;
    n_cmp++; if (PopPC !== 32'h400 || Count !== 3'd1) begin n_err++; $display("FAIL rstmid_restart: got %h cnt=%0d want 400 cnt=1", PopPC, Count); end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
